// File: rtl/smac_pkg.sv
// Shared types and helpers for the SMAC AC1 sequencer: state encoding and
// group-length selection.
package smac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2,
        FIN  = 2'd3
    } ac1_state_t;

    // Beats per group: Pa in 8-bit mode, Pa/2 in 4-bit mode.
    function automatic int grp_len(input int pa, input logic sel);
        return sel ? pa : pa / 2;
    endfunction

endpackage

// File: rtl/smac_ac1_seq_if.sv
// Beat/result handshake and AC1 control bundle between the sequencer
// (master) and the upstream/AC1/AC2 side (slave).
interface smac_ac1_seq_if;
    logic in_valid;
    logic in_ready;
    logic ac1_en;
    logic ac1_first;
    logic ac1_cnt;
    logic cnt_clear;
    logic out_valid;
    logic out_ready;

    modport master (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output ac1_en,
        output ac1_first,
        output ac1_cnt,
        output cnt_clear,
        output out_valid
    );

    modport slave (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  ac1_en,
        input  ac1_first,
        input  ac1_cnt,
        input  cnt_clear,
        input  out_valid
    );
endinterface

// File: rtl/smac_ac1_beat_cnt.sv
// Beat index within the current AC1 group; wraps to 0 after the last beat
// of a group of length len.
module smac_ac1_beat_cnt #(
    parameter int Pa = 8,
    localparam int IDX_W = $clog2(Pa)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [IDX_W:0]   len,
    output logic [IDX_W-1:0] beat_idx,
    output logic             last
);

    assign last = ({1'b0, beat_idx} == (len - 1'b1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx <= '0;
        end else if (clr) begin
            beat_idx <= '0;
        end else if (en) begin
            beat_idx <= last ? '0 : beat_idx + 1'b1;
        end
    end

endmodule

// File: rtl/smac_ac1_seq.sv
// AC1 sequencer: accepts beats, drives AC1 enables, hands group results to AC2.
// Optional stall counter output is built when SMAC_AC1_SEQ_STALL_CNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// ACC   | accepting partial-product beats
// HOLD  | group result presented to AC2
// FIN   | one-cycle job end, done pulse
module smac_ac1_seq
    import smac_pkg::*;
#(
    parameter int Pa    = 8,
    parameter int GRP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             par_sel_Pa,
    input  logic [GRP_W-1:0] n_grp,
    output logic             busy,
    output logic             done,
`ifdef SMAC_AC1_SEQ_STALL_CNT_EN
    output logic [15:0]      stall_cnt,
`endif
    smac_ac1_seq_if.master   bus
);

    localparam int IDX_W = $clog2(Pa);
    localparam int LEN_W = IDX_W + 1;

    ac1_state_t       state;
    ac1_state_t       state_nxt;
    logic             sel_q;
    logic [GRP_W-1:0] n_grp_q;
    logic [GRP_W-1:0] grp_idx;
    logic [IDX_W-1:0] beat_idx;
    logic [LEN_W-1:0] len;
    logic             beat_last;
    logic             grp_last;
    logic             start_ok;
    logic             accept;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             done_q;
    logic             cnt_clear_q;

    assign start_ok = (state == IDLE) && start;
    assign grp_last = (grp_idx == (n_grp_q - 1'b1));
    assign len      = LEN_W'(grp_len(Pa, sel_q));

    smac_ac1_beat_cnt #(.Pa(Pa)) u_beat (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_ok),
        .en       (accept),
        .len      (len),
        .beat_idx (beat_idx),
        .last     (beat_last)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (n_grp != '0) ? ACC : FIN;
            end
            ACC: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (beat_last) state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) state_nxt = grp_last ? FIN : ACC;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake/status outputs are flopped from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            cnt_clear_q <= 1'b0;
            busy        <= 1'b0;
            sel_q       <= 1'b0;
            n_grp_q     <= '0;
            grp_idx     <= '0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt == ACC);
            out_valid_q <= (state_nxt == HOLD);
            done_q      <= (state_nxt == FIN);
            cnt_clear_q <= start_ok;
            if (start_ok) begin
                sel_q   <= par_sel_Pa;
                n_grp_q <= n_grp;
                busy    <= 1'b1;
            end else if (state == FIN) begin
                busy    <= 1'b0;
            end
            if (state == FIN) begin
                grp_idx <= '0;
            end else if ((state == HOLD) && bus.out_ready && !grp_last) begin
                grp_idx <= grp_idx + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.cnt_clear = cnt_clear_q;
    assign bus.ac1_en    = accept;
    assign bus.ac1_cnt   = accept;
    assign bus.ac1_first = accept && (beat_idx == '0);
    assign done          = done_q;

`ifdef SMAC_AC1_SEQ_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
        end else if ((((state == ACC) && !bus.in_valid) ||
                      ((state == HOLD) && !bus.out_ready)) &&
                     (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_smac_ac1_seq.sv
// Self-checking bench for smac_ac1_seq: job-level reference model compared
// every cycle, plus directed jobs with hand-computed totals.
`timescale 1ns/1ps
module tb_smac_ac1_seq;

    localparam int PA    = 8;
    localparam int GRP_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             par_sel_Pa = 1'b0;
    logic [GRP_W-1:0] n_grp = '0;
    logic             busy;
    logic             done;
`ifdef SMAC_AC1_SEQ_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    smac_ac1_seq_if bus();

    smac_ac1_seq #(.Pa(PA), .GRP_W(GRP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .par_sel_Pa (par_sel_Pa),
        .n_grp      (n_grp),
        .busy       (busy),
        .done       (done),
`ifdef SMAC_AC1_SEQ_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Job model: total beats taken and groups handed off decide the phase.
    bit          m_active;
    bit          m_clr;
    int          m_L;
    int          m_N;
    int          m_beats;
    int          m_hs;
    int unsigned m_stall;

    int n_en, n_first, n_cnt, n_hs, n_ov, n_clr, n_done;

    function automatic bit m_acc();
        return m_active && (m_hs < m_N) && (m_beats < (m_hs + 1) * m_L);
    endfunction

    function automatic bit m_pres();
        return m_active && (m_hs < m_N) && (m_beats == (m_hs + 1) * m_L);
    endfunction

    function automatic bit m_fin();
        return m_active && (m_hs == m_N);
    endfunction

    task automatic m_reset();
        m_active = 0; m_clr = 0; m_L = 1; m_N = 0;
        m_beats = 0; m_hs = 0; m_stall = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_counts();
        n_en = 0; n_first = 0; n_cnt = 0; n_hs = 0; n_ov = 0; n_clr = 0; n_done = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"},  bus.in_ready,  0);
        chk({tag, "_ac1_en"},    bus.ac1_en,    0);
        chk({tag, "_ac1_first"}, bus.ac1_first, 0);
        chk({tag, "_ac1_cnt"},   bus.ac1_cnt,   0);
        chk({tag, "_cnt_clear"}, bus.cnt_clear, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_busy"},      busy,          0);
        chk({tag, "_done"},      done,          0);
`ifdef SMAC_AC1_SEQ_STALL_CNT_EN
        chk({tag, "_stall_cnt"}, stall_cnt,     0);
`endif
    endtask

    task automatic compare_cycle();
        bit acc, take;
        acc  = m_acc();
        take = acc && (bus.in_valid === 1'b1);
        chk("in_ready",  bus.in_ready,  acc);
        chk("ac1_en",    bus.ac1_en,    take);
        chk("ac1_cnt",   bus.ac1_cnt,   take);
        chk("ac1_first", bus.ac1_first, take && ((m_beats % m_L) == 0));
        chk("cnt_clear", bus.cnt_clear, m_clr);
        chk("out_valid", bus.out_valid, m_pres());
        chk("done",      done,          m_fin());
        chk("busy",      busy,          m_active);
`ifdef SMAC_AC1_SEQ_STALL_CNT_EN
        chk("stall_cnt", stall_cnt,     m_stall);
`endif
        if (bus.ac1_en === 1'b1)    n_en++;
        if (bus.ac1_first === 1'b1) n_first++;
        if (bus.ac1_cnt === 1'b1)   n_cnt++;
        if (bus.out_valid === 1'b1) n_ov++;
        if ((bus.out_valid === 1'b1) && (bus.out_ready === 1'b1)) n_hs++;
        if (bus.cnt_clear === 1'b1) n_clr++;
        if (done === 1'b1)          n_done++;
    endtask

    task automatic model_step();
        if (!m_active) begin
            m_clr = 0;
            if (start) begin
                m_active = 1; m_clr = 1;
                m_L = par_sel_Pa ? PA : PA / 2;
                m_N = int'(n_grp);
                m_beats = 0; m_hs = 0; m_stall = 0;
            end
        end else begin
            m_clr = 0;
            if (m_fin()) begin
                m_active = 0;
            end else if (m_acc()) begin
                if (bus.in_valid) m_beats++;
                else if (m_stall != 32'hFFFF) m_stall++;
            end else if (m_pres()) begin
                if (bus.out_ready) m_hs++;
                else if (m_stall != 32'hFFFF) m_stall++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        #1 check_all_zero("mid_reset");
        start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic run_job(input bit sel, input int n, input int gap_pct, input int fixed_gaps,
                           input int hold_stall, input int abort_beats, input bit busy_starts,
                           input bit fin_start, output int lat);
        int gaps, hc, beats;
        bit aborted;
        gaps = fixed_gaps; hc = 0; beats = 0; aborted = 0; lat = 0;
        start = 1'b1; par_sel_Pa = sel; n_grp = GRP_W'(n);
        bus.in_valid = 1'($urandom_range(1)); bus.out_ready = 1'($urandom_range(1));
        tick();
        start = 1'b0; par_sel_Pa = 1'($urandom_range(1)); n_grp = GRP_W'($urandom);
        while (!done && lat < 3000) begin
            if (bus.in_ready) begin
                if (gaps > 0) begin bus.in_valid = 1'b0; gaps--; end
                else bus.in_valid = ($urandom_range(99) >= gap_pct);
            end else begin
                bus.in_valid = 1'($urandom_range(1));
            end
            if (bus.out_valid) begin
                bus.out_ready = (hc >= hold_stall); hc++;
            end else begin
                bus.out_ready = 1'($urandom_range(1)); hc = 0;
            end
            start = busy_starts && ($urandom_range(7) == 0);
            if (start) begin par_sel_Pa = 1'($urandom_range(1)); n_grp = GRP_W'($urandom); end
            if (bus.in_ready && bus.in_valid) beats++;
            tick();
            lat++;
            if ((abort_beats != 0) && (beats == abort_beats)) begin
                do_reset();
                aborted = 1;
                break;
            end
        end
        if (!aborted) begin
            chk("job_done_seen", done, 1);
            bus.in_valid = 1'($urandom_range(1)); bus.out_ready = 1'($urandom_range(1));
            start = fin_start;
            tick();
            start = 1'b0;
        end
    endtask

    initial begin
        int lat;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        m_reset();
        clear_counts();
        #2 check_all_zero("reset");
        #10 rst_n = 1'b1;
        repeat (2) tick();

        // 8-bit mode, one group, no stalls
        clear_counts();
        run_job(1, 1, 0, 0, 0, 0, 0, 0, lat);
        chk("t1_latency", lat, 9);
        chk("t1_en_pulses", n_en, 8);
        chk("t1_first_pulses", n_first, 1);
        chk("t1_handshakes", n_hs, 1);
        chk("t1_cnt_clear", n_clr, 1);

        // 4-bit mode, three groups
        clear_counts();
        run_job(0, 3, 0, 0, 0, 0, 0, 0, lat);
        chk("t2_handshakes", n_hs, 3);
        chk("t2_cnt_pulses", n_cnt, 12);
        chk("t2_done_pulses", n_done, 1);
        chk("t2_latency", lat, 15);

        // random beat gaps and 5-cycle AC2 back-pressure
        clear_counts();
        run_job(1, 2, 30, 0, 5, 0, 0, 0, lat);
        chk("t3_out_valid_cycles", n_ov, 12);
        chk("t3_en_pulses", n_en, 16);
        chk("t3_handshakes", n_hs, 2);

        // empty job, with a start issued during the FIN cycle
        clear_counts();
        run_job(1, 0, 0, 0, 0, 0, 0, 1, lat);
        chk("t4_latency", lat, 0);
        chk("t4_en_pulses", n_en, 0);
        chk("t4_out_valid", n_ov, 0);
        chk("t4_done_pulses", n_done, 1);
        repeat (3) tick();
        chk("t4_no_restart_busy", busy, 0);
        chk("t4_cnt_clear", n_clr, 1);

        // reset after 3 beats of group 2, then a clean job
        run_job(0, 3, 0, 0, 0, 7, 0, 0, lat);
        tick();
        clear_counts();
        run_job(0, 2, 0, 0, 0, 0, 0, 0, lat);
        chk("t5_cnt_clear", n_clr, 1);
        chk("t5_first_pulses", n_first, 2);
        chk("t5_en_pulses", n_en, 8);

        // fixed stall pattern: 3 beat gaps + 5 back-pressure cycles
        clear_counts();
        run_job(1, 1, 0, 3, 5, 0, 0, 0, lat);
        chk("t6_out_valid_cycles", n_ov, 6);
        chk("t6_latency", lat, 17);
`ifdef SMAC_AC1_SEQ_STALL_CNT_EN
        chk("t6_stall_cnt", stall_cnt, 8);
`endif

        // randomized jobs with ignored starts while busy
        for (int j = 0; j < 20; j++) begin
            run_job(1'($urandom_range(1)), int'($urandom_range(5, 1)), int'($urandom_range(50)),
                    0, int'($urandom_range(3)), 0, 1, 1'($urandom_range(1)), lat);
            repeat (int'($urandom_range(2))) tick();
        end

        // maximum group count
        clear_counts();
        run_job(0, 255, 0, 0, 0, 0, 0, 0, lat);
        chk("t8_handshakes", n_hs, 255);
        chk("t8_latency", lat, 1275);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
